thiele_xor_sequencer: RTL and testbench

- Synthesizable fetch/decode/execute controller for the simplified Thiele XOR datapath.
- Fetches 32-bit instructions from a synchronous instruction RAM and sequences reads and writes on a single-port data RAM for XOR_LOAD/XOR_ADD/XOR_SWAP.
- Emits PNEW module-table writes and tracks μ-costs, step count and halt/timeout status.
- Sits between the program/data memories and the Python↔Verilog isomorphism checker, which reads its final state after `done`.

---
 rtl/thiele_xor_sequencer_if.sv | 26 ++
 rtl/thiele_xor_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_thiele_xor_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/thiele_xor_sequencer_if.sv
// Memory-side bus of the Thiele XOR sequencer: instruction RAM, data RAM and module-table write port.
// Reads return data one cycle after the address; there is no backpressure on any channel.
interface thiele_xor_sequencer_if #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 10
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic               dmem_we;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic               mod_we;
  logic [5:0]         mod_idx;
  logic [63:0]        mod_mask;

  modport master (
    output imem_addr, dmem_addr, dmem_we, dmem_wdata, mod_we, mod_idx, mod_mask,
    input  imem_rdata, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_we, dmem_wdata, mod_we, mod_idx, mod_mask,
    output imem_rdata, dmem_rdata
  );
endinterface

// File: rtl/thiele_xor_sequencer.sv
// Fetch/decode/execute controller for the Thiele XOR datapath; THIELE_SEQ_UNKNOWN_TRAP_EN traps undefined opcodes.
// Latency: 2 cycles for PNEW/LOAD/EMIT/NOP/HALT, 4 for XOR_ADD, 5 for XOR_SWAP.
// Backpressure: none; both RAMs are assumed ready every cycle with a fixed one-cycle read latency.
module thiele_xor_sequencer #(
  parameter int IMEM_AW       = 8,
  parameter int DMEM_AW       = 10,
  parameter int MAX_MODULES   = 64,
  parameter int TIMEOUT_LIMIT = 10000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  thiele_xor_sequencer_if.master        mem,
  output logic [31:0]                   pc,
  output logic [31:0]                   step_count,
  output logic [31:0]                   num_modules,
  output logic [63:0]                   mu_discovery,
  output logic [63:0]                   mu_execution,
  output logic [63:0]                   mu_total,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic                          trap
);

  localparam logic [7:0] OP_PNEW = 8'h00;
  localparam logic [7:0] OP_LOAD = 8'h0A;
  localparam logic [7:0] OP_ADD  = 8'h0B;
  localparam logic [7:0] OP_SWAP = 8'h0C;
  localparam logic [7:0] OP_EMIT = 8'h0E;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, RD_A, RD_B, WR_B, HALTED, TIMEOUT, TRAP
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        icount, icount_ret;
  logic [7:0]         op_q, a_q, b_q;
  logic [31:0]        op_a_q;
  logic               start_acc, retire, disc_inc, halt_now;
  logic [1:0]         exec_inc;
  logic [DMEM_AW-1:0] d_addr;
  logic               d_we;
  logic [31:0]        d_wdata;
  logic               m_we;
  logic [5:0]         m_idx;
  logic [63:0]        m_mask;

  wire [7:0] dec_op = mem.imem_rdata[31:24];
  wire [7:0] dec_a  = mem.imem_rdata[23:16];
  wire [7:0] dec_b  = mem.imem_rdata[15:8];
  logic unused_instr_bits;
  assign unused_instr_bits = ^mem.imem_rdata[7:0];

  function automatic logic [DMEM_AW-1:0] zext(input logic [7:0] v);
    return {{(DMEM_AW-8){1'b0}}, v};
  endfunction

  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    retire     = 1'b0;
    disc_inc   = 1'b0;
    halt_now   = 1'b0;
    exec_inc   = 2'd0;
    icount_ret = icount;
    d_addr     = '0;
    d_we       = 1'b0;
    d_wdata    = '0;
    m_we       = 1'b0;
    m_idx      = '0;
    m_mask     = '0;
    case (state)
      IDLE, HALTED, TIMEOUT, TRAP: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        icount_ret = icount + 32'd1;
        case (dec_op)
          OP_PNEW: begin
            retire = 1'b1;
            if (num_modules < 32'(MAX_MODULES)) begin
              m_we     = 1'b1;
              m_idx    = num_modules[5:0];
              m_mask   = (dec_a < 8'd64) ? (64'h1 << dec_a[5:0]) : 64'h0;
              disc_inc = 1'b1;
            end
          end
          OP_LOAD: begin
            retire   = 1'b1;
            d_we     = 1'b1;
            d_addr   = zext(dec_a);
            d_wdata  = {24'h0, dec_b};
            exec_inc = 2'd1;
          end
          OP_ADD, OP_SWAP: begin
            d_addr    = zext(dec_a);
            state_nxt = RD_A;
          end
          OP_EMIT: retire = 1'b1;
          OP_HALT: begin
            halt_now  = 1'b1;
            state_nxt = HALTED;
          end
`ifdef THIELE_SEQ_UNKNOWN_TRAP_EN
          default: state_nxt = TRAP;
`else
          default: retire = 1'b1;
`endif
        endcase
      end
      RD_A: begin
        d_addr    = zext(b_q);
        state_nxt = RD_B;
      end
      RD_B: begin
        d_we   = 1'b1;
        d_addr = zext(a_q);
        if (op_q == OP_SWAP) begin
          d_wdata   = mem.dmem_rdata;
          state_nxt = WR_B;
        end else begin
          d_wdata  = op_a_q ^ mem.dmem_rdata;
          retire   = 1'b1;
          exec_inc = 2'd1;
        end
      end
      WR_B: begin
        // a==b must end at zero, as three sequential XORs on one cell would
        d_we     = 1'b1;
        d_addr   = zext(b_q);
        d_wdata  = (a_q == b_q) ? 32'h0 : op_a_q;
        retire   = 1'b1;
        exec_inc = 2'd3;
      end
      default: state_nxt = IDLE;
    endcase
    if (retire) state_nxt = (icount_ret >= 32'(TIMEOUT_LIMIT)) ? TIMEOUT : FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      step_count   <= '0;
      num_modules  <= '0;
      mu_discovery <= '0;
      mu_execution <= '0;
      mu_total     <= '0;
      icount       <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_a_q       <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        pc           <= '0;
        step_count   <= '0;
        num_modules  <= '0;
        mu_discovery <= '0;
        mu_execution <= '0;
        mu_total     <= '0;
        icount       <= '0;
      end else begin
        if (state == DECODE) begin
          op_q   <= dec_op;
          a_q    <= dec_a;
          b_q    <= dec_b;
          icount <= icount_ret;
        end
        if (state == RD_A) op_a_q <= mem.dmem_rdata;
        if (retire) begin
          pc         <= pc + 32'd1;
          step_count <= step_count + 32'd1;
        end
        if (disc_inc) begin
          num_modules  <= num_modules + 32'd1;
          mu_discovery <= mu_discovery + 64'd1;
        end
        mu_execution <= mu_execution + {62'd0, exec_inc};
        if (halt_now) mu_total <= mu_discovery + mu_execution;
      end
    end
  end

  assign mem.imem_addr  = pc[IMEM_AW-1:0];
  assign mem.dmem_addr  = d_addr;
  assign mem.dmem_we    = d_we;
  assign mem.dmem_wdata = d_wdata;
  assign mem.mod_we     = m_we;
  assign mem.mod_idx    = m_idx;
  assign mem.mod_mask   = m_mask;

  assign busy    = (state == FETCH) || (state == DECODE) || (state == RD_A) ||
                   (state == RD_B)  || (state == WR_B);
  assign done    = (state == HALTED);
  assign timeout = (state == TIMEOUT);
`ifdef THIELE_SEQ_UNKNOWN_TRAP_EN
  assign trap    = (state == TRAP);
`else
  assign trap    = 1'b0;
`endif

endmodule

// File: tb/tb_thiele_xor_sequencer.sv
// Directed bench for thiele_xor_sequencer with behavioural instruction/data RAMs and a module-table write log.
module tb_thiele_xor_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc, step_count, num_modules;
  logic [63:0] mu_discovery, mu_execution, mu_total;
  logic        busy, done, timeout, trap;

  thiele_xor_sequencer_if #(.IMEM_AW(8), .DMEM_AW(10)) bus ();

  thiele_xor_sequencer #(
    .IMEM_AW(8), .DMEM_AW(10), .MAX_MODULES(64), .TIMEOUT_LIMIT(10000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem(bus),
    .pc(pc), .step_count(step_count), .num_modules(num_modules),
    .mu_discovery(mu_discovery), .mu_execution(mu_execution), .mu_total(mu_total),
    .busy(busy), .done(done), .timeout(timeout), .trap(trap)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [1024];
  logic [5:0]  log_idx  [256];
  logic [63:0] log_mask [256];
  int we_cnt  = 0;
  int mod_cnt = 0;

  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

  always @(posedge clk) begin
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    bus.dmem_rdata <= dmem[bus.dmem_addr];
  end

  always @(posedge clk) begin
    if (bus.dmem_we) we_cnt <= we_cnt + 1;
    if (bus.mod_we) begin
      log_idx[mod_cnt[7:0]]  <= bus.mod_idx;
      log_mask[mod_cnt[7:0]] <= bus.mod_mask;
      mod_cnt <= mod_cnt + 1;
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFF000000;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int bound, input string tag);
    int n = 0;
    while (!(done || timeout || trap) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, (done || timeout || trap)}, 64'd1);
  endtask

  int we_base, mod_base;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_step", step_count, 0);
    check("rst_nmod", num_modules, 0);
    check("rst_mu_total", mu_total, 0);
    check("rst_flags", {busy, done, timeout, trap}, 0);
    check("rst_bus", {bus.imem_addr, bus.dmem_addr, bus.dmem_we, bus.mod_we, bus.mod_mask}, 0);
    rst = 1'b0;

    // LOAD/LOAD/ADD/HALT with exact cycle timing
    clear_imem();
    imem[0] = 32'h0A000500; imem[1] = 32'h0A010300; imem[2] = 32'h0B000100;
    pulse_start();
    check("t1_busy_fetch", busy, 1);
    repeat (9) @(negedge clk);
    check("t1_done_early", done, 0);
    @(negedge clk);
    check("t1_done_11", done, 1);
    check("t1_dmem0", dmem[0], 6);
    check("t1_dmem1", dmem[1], 3);
    check("t1_mu_exec", mu_execution, 3);
    check("t1_mu_total", mu_total, 3);
    check("t1_step", step_count, 3);
    check("t1_pc", pc, 3);
    check("t1_busy", busy, 0);

    // PNEW with in-range and out-of-range operand
    clear_imem();
    imem[0] = 32'h00030000; imem[1] = 32'h00450000;
    mod_base = mod_cnt;
    pulse_start();
    wait_end(100, "t2_end");
    check("t2_nwrites", mod_cnt - mod_base, 2);
    check("t2_idx0", log_idx[mod_base], 0);
    check("t2_mask0", log_mask[mod_base], 64'h8);
    check("t2_idx1", log_idx[mod_base+1], 1);
    check("t2_mask1", log_mask[mod_base+1], 64'h0);
    check("t2_nmod", num_modules, 2);
    check("t2_mu_disc", mu_discovery, 2);
    check("t2_mu_exec_cleared", mu_execution, 0);
    check("t2_mu_total", mu_total, 2);

    // module table saturates at 64 entries
    clear_imem();
    for (int i = 0; i < 65; i++) imem[i] = 32'h00000000;
    mod_base = mod_cnt;
    pulse_start();
    wait_end(300, "tfull_end");
    check("tfull_nwrites", mod_cnt - mod_base, 64);
    check("tfull_last_idx", log_idx[mod_base+63], 63);
    check("tfull_nmod", num_modules, 64);
    check("tfull_mu_disc", mu_discovery, 64);
    check("tfull_step", step_count, 65);

    // SWAP of distinct cells
    clear_imem();
    imem[0] = 32'h0A020700; imem[1] = 32'h0A040900; imem[2] = 32'h0C020400;
    pulse_start();
    wait_end(100, "t3_end");
    check("t3_dmem2", dmem[2], 9);
    check("t3_dmem4", dmem[4], 7);
    check("t3_mu_exec", mu_execution, 5);

    // SWAP of a cell with itself
    clear_imem();
    imem[0] = 32'h0A020700; imem[1] = 32'h0C020200;
    pulse_start();
    wait_end(100, "t3b_end");
    check("t3b_dmem2", dmem[2], 0);
    check("t3b_mu_exec", mu_execution, 4);

    // EMIT in every slot runs into the instruction limit
    for (int i = 0; i < 256; i++) imem[i] = 32'h0E000000;
    pulse_start();
    wait_end(21000, "t4_end");
    check("t4_timeout", timeout, 1);
    check("t4_done", done, 0);
    check("t4_step", step_count, 10000);
    check("t4_pc", pc, 10000);
    check("t4_imem_addr", bus.imem_addr, 16);
    check("t4_mu_total", mu_total, 0);

    // undefined opcode
    clear_imem();
    imem[0] = 32'h5A000000;
    pulse_start();
    wait_end(100, "t5_end");
`ifdef THIELE_SEQ_UNKNOWN_TRAP_EN
    check("t5_trap", trap, 1);
    check("t5_pc", pc, 0);
    check("t5_step", step_count, 0);
    check("t5_done", done, 0);
`else
    check("t5_trap", trap, 0);
    check("t5_step", step_count, 1);
    check("t5_done", done, 1);
    check("t5_timeout_cleared", timeout, 0);
`endif

    // reset while XOR_ADD is in RD_B
    clear_imem();
    imem[0] = 32'h0A080500; imem[1] = 32'h0A090300; imem[2] = 32'h0B080900;
    we_base = we_cnt;
    pulse_start();
    repeat (7) @(negedge clk);
    check("t6_busy_rdb", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_we_count", we_cnt - we_base, 2);
    check("t6_dmem8_kept", dmem[8], 5);
    check("t6_outputs_zero", {pc, step_count, mu_execution, busy, done, bus.dmem_we}, 0);
    rst = 1'b0;
    pulse_start();
    wait_end(100, "t6_rerun_end");
    check("t6_dmem8", dmem[8], 6);
    check("t6_step", step_count, 3);
    check("t6_mu_total", mu_total, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
